// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the decode stage: opcode encodings, field widths
// and instruction field-extraction helpers.
//   Instruction layout (MSB to LSB): opcode[4], rs1[REG_AW], rs2[REG_AW], rd[REG_AW]
package decode_pkg;

   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_LOAD = 4'h8;
   localparam logic [OPC_W-1:0] OP_BEQ  = 4'hC;

   // Number of combinational read ports on the register file (rs1, rs2).
   localparam int RD_PORTS = 2;

   // Helpers operate on a zero-extended instruction of this width, so the
   // largest supported REG_AW is 8 (INST_W = 28).
   localparam int MAX_INST_W = 32;
   localparam int MAX_REG_AW = 8;

   function automatic logic [OPC_W-1:0] inst_opcode(input logic [MAX_INST_W-1:0] inst,
                                                    input int reg_aw);
      return OPC_W'(inst >> (3 * reg_aw));
   endfunction

   // Register field number pos (0 = rd, 1 = rs2, 2 = rs1).
   function automatic logic [MAX_REG_AW-1:0] inst_field(input logic [MAX_INST_W-1:0] inst,
                                                        input int reg_aw,
                                                        input int pos);
      logic [MAX_INST_W-1:0] mask;
      mask = (MAX_INST_W'(1) << reg_aw) - MAX_INST_W'(1);
      return MAX_REG_AW'((inst >> (pos * reg_aw)) & mask);
   endfunction

   function automatic logic [MAX_REG_AW-1:0] inst_rs1(input logic [MAX_INST_W-1:0] inst,
                                                      input int reg_aw);
      return inst_field(inst, reg_aw, 2);
   endfunction

   function automatic logic [MAX_REG_AW-1:0] inst_rs2(input logic [MAX_INST_W-1:0] inst,
                                                      input int reg_aw);
      return inst_field(inst, reg_aw, 1);
   endfunction

   function automatic logic [MAX_REG_AW-1:0] inst_rd(input logic [MAX_INST_W-1:0] inst,
                                                     input int reg_aw);
      return inst_field(inst, reg_aw, 0);
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile
// 2**REG_AW x DATA_W register file, one write port, RD_PORTS combinational
// read ports. With BYPASS=1 a read of the register being written this cycle
// returns the incoming write data.
//   clk, reset      clock, asynchronous active-high reset (clears all registers)
//   write_en        write-back enable
//   write_addr      write-back register address
//   write_data      write-back data
//   read_addr[p]    read address of port p
//   read_data[p]    read data of port p
module decode_regfile
   import decode_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int BYPASS = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               write_en,
   input  logic [REG_AW-1:0]                  write_addr,
   input  logic [DATA_W-1:0]                  write_data,
   input  logic [RD_PORTS-1:0][REG_AW-1:0]    read_addr,
   output logic [RD_PORTS-1:0][DATA_W-1:0]    read_data
);

   localparam int DEPTH = 1 << REG_AW;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
         if (BYPASS != 0) begin : g_byp
            assign read_data[gi] = (write_en && (write_addr == read_addr[gi])) ?
                                   write_data : mem[read_addr[gi]];
         end else begin : g_nobyp
            assign read_data[gi] = mem[read_addr[gi]];
         end
      end
   endgenerate

endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage
// Decode stage between fetch and execute: splits the instruction, reads
// operands (with write-back bypass), detects load-use hazards, resolves
// equality branches and holds the result in a D/E register with a
// valid/ready handshake.
//   in_valid/in_ready, i_inst, pcD, immediateC   fetch side
//   write_en, destAddW, i_write_data             write-back port
//   ex_ready, out_valid, opcodeE, destaddE,
//   srcdataE1, srcdataE2, pcE                    D/E register / execute side
//   branch_taken, PC_branch                      one-cycle fetch redirect
//   flush_i                                      kill D/E and pending branch
//   hazard_stall                                 load-use stall (combinational)
module decode_pipe_stage
   import decode_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int REG_AW = 4,
   parameter  int PC_W   = 12,
   parameter  int BYPASS = 1,
   localparam int INST_W = OPC_W + 3 * REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] i_inst,
   input  logic [PC_W-1:0]   pcD,
   input  logic              immediateC,
   input  logic              write_en,
   input  logic [REG_AW-1:0] destAddW,
   input  logic [DATA_W-1:0] i_write_data,
   input  logic              ex_ready,
   input  logic              flush_i,
   output logic              out_valid,
   output logic [OPC_W-1:0]  opcodeE,
   output logic [REG_AW-1:0] destaddE,
   output logic [DATA_W-1:0] srcdataE1,
   output logic [DATA_W-1:0] srcdataE2,
   output logic [PC_W-1:0]   pcE,
   output logic              branch_taken,
   output logic [PC_W-1:0]   PC_branch,
   output logic              hazard_stall
);

   logic [MAX_INST_W-1:0]            inst_ext;
   logic [OPC_W-1:0]                 opcode;
   logic [REG_AW-1:0]                rs1, rs2, rd;
   logic [RD_PORTS-1:0][REG_AW-1:0]  read_addr;
   logic [RD_PORTS-1:0][DATA_W-1:0]  read_data;
   logic [DATA_W-1:0]                operand1, operand2;
   logic [PC_W-1:0]                  target;
   logic                             accept, squash, beq_taken;

   assign inst_ext = MAX_INST_W'(i_inst);
   assign opcode   = inst_opcode(inst_ext, REG_AW);
   assign rs1      = REG_AW'(inst_rs1(inst_ext, REG_AW));
   assign rs2      = REG_AW'(inst_rs2(inst_ext, REG_AW));
   assign rd       = REG_AW'(inst_rd(inst_ext, REG_AW));

   assign read_addr[0] = rs1;
   assign read_addr[1] = rs2;

   decode_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .BYPASS (BYPASS)
   ) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .write_en   (write_en),
      .write_addr (destAddW),
      .write_data (i_write_data),
      .read_addr  (read_addr),
      .read_data  (read_data)
   );

   assign operand1 = read_data[0];
   // Immediate form: {rs2,rd} zero-extended to the operand width.
   assign operand2 = immediateC ? DATA_W'({rs2, rd}) : read_data[1];

   // rd doubles as a signed branch offset; the add wraps at PC_W bits.
   assign target = pcD + PC_W'($signed(rd));

   // A LOAD sitting in D/E whose destination feeds the offered instruction.
   assign hazard_stall = in_valid && out_valid && (opcodeE == OP_LOAD) &&
                         ((destaddE == rs1) || (!immediateC && (destaddE == rs2)));

   assign in_ready = (ex_ready || !out_valid) && !hazard_stall && !flush_i;
   assign accept   = in_valid && in_ready;

   // The cycle after a taken branch the offered instruction is wrong-path.
   assign squash    = branch_taken;
   assign beq_taken = (opcode == OP_BEQ) && (operand1 == operand2) && !squash;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         opcodeE      <= '0;
         destaddE     <= '0;
         srcdataE1    <= '0;
         srcdataE2    <= '0;
         pcE          <= '0;
         branch_taken <= 1'b0;
         PC_branch    <= '0;
      end else begin
         branch_taken <= 1'b0;
         if (flush_i) begin
            out_valid <= 1'b0;
         end else if (hazard_stall) begin
            // Bubble into execute; the stall clears once the LOAD leaves D/E.
            if (ex_ready) begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            if (squash || (opcode == OP_BEQ)) begin
               out_valid <= 1'b0;
            end else begin
               out_valid <= 1'b1;
               opcodeE   <= opcode;
               destaddE  <= rd;
               srcdataE1 <= operand1;
               srcdataE2 <= operand2;
               pcE       <= pcD;
            end
            if (beq_taken) begin
               branch_taken <= 1'b1;
               PC_branch    <= target;
            end
         end else if (ex_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
